mdu_div32: RTL and testbench
============================

Name: mdu_div32

Overview:
- Multi-cycle 32-bit integer divider for the EX stage of the 5-stage MIPS32 pipeline; executes DIV and DIVU and produces quotient (LO) and remainder (HI).
- Consumes operands and the start request from the ID/EX pipeline register.
- Drives stall_req, which holds the PC, IF/ID and ID/EX registers and makes the hazard logic flush EX/MEM until the result is ready.
- Radix-2 restoring algorithm on operand magnitudes, followed by sign correction.

Parameters:
- XLEN, 32, operand/result width; only 32 is supported.
- ITER, 32, iteration count; must equal XLEN.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low
- flush  in  1  synchronous kill of any in-flight divide
- start  in  1  ID/EX holds a DIV/DIVU; level signal, held while stalled
- is_signed  in  1  1 = DIV, 0 = DIVU; sampled with start
- dividend  in  32  rs operand; sampled with start
- divisor  in  32  rt operand; sampled with start
- busy  out  1  registered; high in RUN
- done  out  1  registered; one-cycle pulse, results valid
- stall_req  out  1  combinational: (state==IDLE && start && !flush) || state==RUN
- quotient  out  32  registered; to LO
- remainder  out  32  registered; to HI

Behaviour:
- Reset (rst=0, async): state=IDLE; busy=0; done=0; quotient=0; remainder=0; internal registers=0.
- States:
  - IDLE -> RUN on a posedge with start=1 and flush=0. Latch operand magnitudes, result signs and the divisor==0 flag. Iteration counter = 0.
  - RUN: one shift/subtract step per edge. After the 32nd step (counter==31), go to DONE and write quotient/remainder on the same edge.
  - DONE -> IDLE unconditionally on the next edge. start is ignored in DONE because it still belongs to the just-completed instruction.
- Latency: start first seen high at edge E0. done is high in the cycle after edge E32, i.e. 33 cycles from the start cycle.
- stall_req is high from the start cycle through the last RUN cycle and low in the DONE cycle, so the pipeline advances exactly while done=1.
- busy=1 iff state==RUN. done=1 iff state==DONE.
- quotient and remainder change only on the RUN->DONE edge and hold their value otherwise, including after flush.
- Arithmetic:
  - Unsigned: plain restoring division. Partial remainder is 33 bits wide to hold the borrow.
  - Signed: divide magnitudes. Negate the quotient iff the operand signs differ. The remainder takes the sign of the dividend.
  - |-2^31| is the unsigned value 0x80000000, with no overflow in the magnitude.
- Boundary conditions:
  - Divisor == 0 (either mode): full 33-cycle latency; quotient=0xFFFF_FFFF, remainder=dividend (original bit pattern); no exception.
  - DIV 0x80000000 / 0xFFFFFFFF: quotient=0x80000000, remainder=0.
  - Dividend 0: quotient=0, remainder=0.
- Flush: synchronous, highest priority after reset. From any state it forces IDLE, busy=0 and done=0 at the next edge. Outputs are not updated. flush together with start in IDLE does not launch.
- Reset mid-operation: immediate return to the reset values, with no done pulse afterwards.
- Operand changes during RUN are ignored; only the values latched at launch are used.

Test Plan:
- DIVU 100/7, start held high until done -> done pulse exactly 33 cycles after the start cycle; quotient=14, remainder=2; stall_req high for 33 cycles then low during done; no relaunch in the DONE cycle.
- DIV 0xFFFFFFF9 (-7) / 2 -> quotient=0xFFFFFFFD, remainder=0xFFFFFFFF. DIV 7 / 0xFFFFFFFE (-2) -> quotient=0xFFFFFFFD, remainder=1.
- DIV 0x80000000 / 0xFFFFFFFF -> quotient=0x80000000, remainder=0. DIVU 0xFFFFFFFF/1 -> quotient=0xFFFFFFFF, remainder=0.
- Divide by zero: DIVU 12345/0 and DIV 0xFFFFFF00/0 -> quotient=0xFFFFFFFF, remainder equal to the dividend; latency still 33 cycles.
- flush pulse in RUN cycle 10 of DIVU 50/5 -> busy=0 next edge, no done, quotient/remainder keep their prior values. A following start of DIVU 9/4 -> quotient=2, remainder=1 after 33 cycles.
- rst asserted asynchronously mid-RUN -> busy, done, quotient and remainder are 0 immediately. After release with start=1 (DIVU 1000/3), a clean launch gives quotient=333, remainder=1. Back-to-back instructions (start held high across the IDLE gap) each produce exactly one done.

Source files
------------

// File: rtl/mdu_div32.sv
// mdu_div32 - multi-cycle 32-bit integer divider (DIV / DIVU) for the EX stage.
//
// Radix-2 restoring division on operand magnitudes, one step per clock,
// followed by sign correction on the final step. IDLE -> RUN (32 steps) ->
// DONE (one-cycle result pulse) -> IDLE.
//
// Ports:
//   clk, rst        clock; asynchronous active-low reset
//   flush           synchronous kill of any in-flight divide (no result write)
//   start           ID/EX holds a DIV/DIVU (level, held while stalled)
//   is_signed       1 = DIV, 0 = DIVU; sampled with start
//   dividend/divisor operands; sampled with start
//   busy            high while in RUN
//   done            one-cycle pulse, quotient/remainder valid
//   stall_req       holds the front of the pipe until the result is ready
//   quotient        to LO
//   remainder       to HI
module mdu_div32 #(
  parameter int XLEN = 32,
  parameter int ITER = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            start,
  input  logic            is_signed,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  output logic            busy,
  output logic            done,
  output logic            stall_req,
  output logic [XLEN-1:0] quotient,
  output logic [XLEN-1:0] remainder
);

  localparam int CW = $clog2(ITER);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state, state_nxt;
  logic [CW-1:0]   cnt;
  logic [XLEN:0]   prem;      // partial remainder, extra bit holds the borrow
  logic [XLEN-1:0] quo_sr;    // dividend magnitude shifts out, quotient bits shift in
  logic [XLEN-1:0] dvs_mag;
  logic [XLEN-1:0] dvd_orig;  // raw dividend, returned as remainder on divide-by-zero
  logic            q_neg, r_neg, dz;

  logic            launch, step, last;
  logic [XLEN-1:0] dvd_m, dvs_m;
  logic [XLEN:0]   prem_sh, prem_dif, prem_nxt;
  logic [XLEN-1:0] quo_nxt, q_fin, r_fin;

  assign launch    = (state == IDLE) && start && !flush;
  assign step      = (state == RUN) && !flush;
  assign last      = (cnt == CW'(ITER - 1));
  assign busy      = (state == RUN);
  assign done      = (state == DONE);
  assign stall_req = launch || (state == RUN);

  // |-2^31| wraps to 0x80000000, which is the correct unsigned magnitude.
  assign dvd_m = (is_signed && dividend[XLEN-1]) ? -dividend : dividend;
  assign dvs_m = (is_signed && divisor[XLEN-1])  ? -divisor  : divisor;

  // One restoring step: shift in the next dividend bit, try the subtract,
  // keep the difference only if it did not borrow.
  always_comb begin
    prem_sh  = {prem[XLEN-1:0], quo_sr[XLEN-1]};
    prem_dif = prem_sh - {1'b0, dvs_mag};
    prem_nxt = prem_sh;
    quo_nxt  = {quo_sr[XLEN-2:0], 1'b0};
    if (!prem_dif[XLEN]) begin
      prem_nxt = prem_dif;
      quo_nxt  = {quo_sr[XLEN-2:0], 1'b1};
    end
    q_fin = dz ? '1       : (q_neg ? -quo_nxt : quo_nxt);
    r_fin = dz ? dvd_orig : (r_neg ? -prem_nxt[XLEN-1:0] : prem_nxt[XLEN-1:0]);
  end

  always_comb begin
    state_nxt = state;
    if (flush) state_nxt = IDLE;
    else begin
      case (state)
        IDLE:    if (start) state_nxt = RUN;
        RUN:     if (last)  state_nxt = DONE;
        DONE:    state_nxt = IDLE;  // start here still belongs to the finished op
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      cnt       <= '0;
      prem      <= '0;
      quo_sr    <= '0;
      dvs_mag   <= '0;
      dvd_orig  <= '0;
      q_neg     <= 1'b0;
      r_neg     <= 1'b0;
      dz        <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
    end else begin
      state <= state_nxt;
      if (launch) begin
        cnt      <= '0;
        prem     <= '0;
        quo_sr   <= dvd_m;
        dvs_mag  <= dvs_m;
        dvd_orig <= dividend;
        q_neg    <= is_signed && (dividend[XLEN-1] ^ divisor[XLEN-1]);
        r_neg    <= is_signed && dividend[XLEN-1];
        dz       <= (divisor == '0);
      end else if (step) begin
        cnt    <= cnt + 1'b1;
        prem   <= prem_nxt;
        quo_sr <= quo_nxt;
        if (last) begin
          quotient  <= q_fin;
          remainder <= r_fin;
        end
      end
    end
  end

endmodule

// File: tb/tb_mdu_div32.sv
// Testbench for mdu_div32: directed boundary cases, flush, async reset,
// back-to-back launches and randomized operands against a plain-arithmetic
// reference model.
module tb_mdu_div32;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        flush = 1'b0;
  logic        start = 1'b0;
  logic        is_signed = 1'b0;
  logic [31:0] dividend = '0;
  logic [31:0] divisor = '0;
  logic        busy, done, stall_req;
  logic [31:0] quotient, remainder;

  int total = 0;
  int bad = 0;

  mdu_div32 #(.XLEN(32), .ITER(32)) dut (
    .clk(clk), .rst(rst), .flush(flush), .start(start), .is_signed(is_signed),
    .dividend(dividend), .divisor(divisor), .busy(busy), .done(done),
    .stall_req(stall_req), .quotient(quotient), .remainder(remainder)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: MIPS DIV/DIVU semantics from plain integer arithmetic.
  function automatic void ref_div(input bit s, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] q, output logic [31:0] r);
    longint sa, sb;
    if (b == 0) begin
      q = 32'hFFFF_FFFF;
      r = a;
    end else if (s) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      q  = 32'(sa / sb);
      r  = 32'(sa % sb);
    end else begin
      q = a / b;
      r = a % b;
    end
  endfunction

  // Called at negedge+1 of the intended start cycle. Leaves start high and
  // returns at negedge+1 of the IDLE cycle following the done pulse.
  task automatic run_op(input string tag, input bit s, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] eq, input logic [31:0] er);
    int cyc;
    bit stall_ok;
    start = 1'b1; is_signed = s; dividend = a; divisor = b;
    #1;
    cyc = 0;
    stall_ok = 1'b1;
    while (!done && cyc < 60) begin
      if (!stall_req) stall_ok = 1'b0;
      @(negedge clk); #1;
      cyc++;
      if (cyc == 2) begin  // operands must be ignored once launched
        dividend = $urandom; divisor = $urandom; is_signed = 1'($urandom);
      end
    end
    chk({tag, "_latency"}, 32'(cyc), 32'd33);
    chk({tag, "_stall_run"}, 32'(stall_ok), 32'd1);
    chk({tag, "_stall_done"}, 32'(stall_req), 32'd0);
    chk({tag, "_busy_done"}, 32'(busy), 32'd0);
    chk({tag, "_quot"}, quotient, eq);
    chk({tag, "_rem"}, remainder, er);
    @(negedge clk); #1;
    chk({tag, "_no_relaunch"}, {30'd0, busy, done}, 32'd0);
  endtask

  initial begin
    logic [31:0] a, b, eq, er, hold_q, hold_r;
    bit s, seen;

    #3;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_quot", quotient, 32'd0);
    chk("rst_rem", remainder, 32'd0);
    @(negedge clk); #1;
    rst = 1'b1;
    @(negedge clk); #1;

    // Directed cases, start held high across the IDLE gaps (back-to-back).
    run_op("divu_100_7", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2);
    run_op("div_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF);
    run_op("div_7_m2", 1'b1, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1);
    run_op("div_ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0);
    run_op("divu_max_1", 1'b0, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0);
    run_op("divu_dz", 1'b0, 32'd12345, 32'd0, 32'hFFFF_FFFF, 32'd12345);
    run_op("div_dz", 1'b1, 32'hFFFF_FF00, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FF00);
    run_op("div_zero_dvd", 1'b1, 32'd0, 32'hFFFF_FFFB, 32'd0, 32'd0);
    start = 1'b0;
    @(negedge clk); #1;
    hold_q = 32'd0; hold_r = 32'd0;  // last directed result (0/-5)

    // flush with start in IDLE must not launch
    start = 1'b1; is_signed = 1'b0; dividend = 32'd50; divisor = 32'd5; flush = 1'b1;
    #1;
    chk("flush_idle_stall", 32'(stall_req), 32'd0);
    @(negedge clk); #1;
    chk("flush_idle_busy", 32'(busy), 32'd0);
    flush = 1'b0;
    @(negedge clk); #1;             // RUN cycle 1
    chk("run_busy", 32'(busy), 32'd1);
    start = 1'b0;
    repeat (9) @(negedge clk);
    #1;                              // RUN cycle 10
    flush = 1'b1;
    @(negedge clk); #1;
    flush = 1'b0;
    chk("flush_run_busy", 32'(busy), 32'd0);
    chk("flush_run_done", 32'(done), 32'd0);
    chk("flush_hold_quot", quotient, hold_q);
    chk("flush_hold_rem", remainder, hold_r);
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    #1;
    chk("flush_no_done", 32'(seen), 32'd0);
    run_op("divu_9_4", 1'b0, 32'd9, 32'd4, 32'd2, 32'd1);
    start = 1'b0;
    @(negedge clk); #1;

    // async reset mid-RUN
    start = 1'b1; is_signed = 1'b0; dividend = 32'd77; divisor = 32'd5;
    repeat (6) @(negedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_done", 32'(done), 32'd0);
    chk("arst_quot", quotient, 32'd0);
    chk("arst_rem", remainder, 32'd0);
    @(negedge clk); #1;
    rst = 1'b1;
    run_op("divu_1000_3", 1'b0, 32'd1000, 32'd3, 32'd333, 32'd1);
    start = 1'b0;
    @(negedge clk); #1;

    // randomized operands against the reference model
    for (int k = 0; k < 20; k++) begin
      a = $urandom;
      s = 1'($urandom);
      if (k % 5 == 0)      b = 32'd0;
      else if (k % 3 == 0) b = 32'($urandom_range(1, 15));
      else                 b = $urandom;
      if (k % 7 == 3) a = 32'h8000_0000;
      if (k % 4 == 1) b = -b;
      ref_div(s, a, b, eq, er);
      run_op("rand", s, a, b, eq, er);
      if (k % 2 == 1) begin
        start = 1'b0;
        @(negedge clk); #1;
      end
    end
    start = 1'b0;
    @(negedge clk); #1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
